cpu7_ifu_imem_resp: RTL and testbench

- Responder end of the instruction fetch request/response interface: accepts `inst_req`/`inst_addr`, returns `inst_addr_ok`, then `inst_valid` with a 128-bit fetch group, count, exception and uncache flags.
- Sits between the front-end fetch datapath and a synchronous single-port instruction SRAM with a 128-bit line and fixed 1-cycle read latency.
- Adds programmable wait states to model slow memory, and honours `inst_cancel`.

---
 rtl/cpu7_ifu_imem_resp.sv | 161 ++++++++++++++++
 tb/tb_cpu7_ifu_imem_resp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_ifu_imem_resp.sv
// cpu7_ifu_imem_resp: responder end of the instruction fetch req/resp interface.
// It accepts fetch requests, reads a 128-bit line from a 1-cycle-latency SRAM
// after WAIT_CYCLES extra cycles, and returns the line starting at the requested word.
// Misaligned requests and requests outside the SRAM window return an ADEF exception.
// The optional macro CPU7_IMEM_UNCACHE_EN marks addresses with bits [31:29]==3'b101 as uncached.
// An uncached response carries only the requested word.

module cpu7_ifu_imem_resp #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h1c00_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_req,
  input  logic [31:0]           inst_addr,
  input  logic                  inst_cancel,
  output logic                  inst_addr_ok,
  output logic                  inst_valid,
  output logic [127:0]          inst_rdata,
  output logic [1:0]            inst_count,
  output logic                  inst_ex,
  output logic [5:0]            inst_exccode,
  output logic                  inst_uncache,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [127:0]          ram_rdata
);

  localparam int unsigned WIN_BITS  = ADDR_WIDTH + 4;
  localparam logic [31:0] WIN_MASK  = 32'((64'd1 << WIN_BITS) - 64'd1);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [5:0]  EXC_ADEF  = 6'h08;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_EXC
  } state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] line_q;

  logic                  accept_state;
  logic                  handshake;
  logic                  addr_fault;
  logic [ADDR_WIDTH-1:0] req_line;
  logic [127:0]          shifted;

  // The SRAM window is aligned to its own size, so the line index is simply the address bits above the byte offset.
  assign req_line     = inst_addr[ADDR_WIDTH+3:4];
  assign addr_fault   = (inst_addr[1:0] != 2'b00) || ((inst_addr & ~WIN_MASK) != BASE_ADDR);
  assign accept_state = (state == S_IDLE) || (state == S_RD);
  assign inst_addr_ok = inst_req & ~inst_cancel & ~reset & accept_state;
  assign handshake    = inst_req & inst_addr_ok;

  // Main sequencer: a cancel always returns to IDLE; the RD state can take a new request to give back-to-back fetches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      off_q    <= 2'd0;
      line_q   <= '0;
    end else if (inst_cancel) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_RD: begin
          if (handshake) begin
            off_q  <= inst_addr[3:2];
            line_q <= req_line;
            if (addr_fault) begin
              state <= S_EXC;
            end else if (WAIT_CYCLES == 0) begin
              state <= S_RD;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_RD;
          end
        end
        S_EXC: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CPU7_IMEM_UNCACHE_EN
  logic unc_q;

  // Remember whether the accepted request targets the uncached segment.
  always_ff @(posedge clock) begin
    if (reset) begin
      unc_q <= 1'b0;
    end else if (handshake && !inst_cancel) begin
      unc_q <= (inst_addr[31:29] == 3'b101);
    end
  end
`endif

  // Response and SRAM control decode; reset and cancel suppress everything visible this cycle.
  always_comb begin
    inst_valid   = 1'b0;
    inst_rdata   = '0;
    inst_count   = 2'd0;
    inst_ex      = 1'b0;
    inst_exccode = 6'd0;
    inst_uncache = 1'b0;
    ram_en       = 1'b0;
    ram_addr     = reset ? '0 : line_q;
    shifted      = ram_rdata >> {off_q, 5'b0_0000};
    if (!reset && !inst_cancel) begin
      if (handshake && !addr_fault && (WAIT_CYCLES == 0)) begin
        ram_en   = 1'b1;
        ram_addr = req_line;
      end
      if ((state == S_WAIT) && (wait_cnt == 4'd1)) begin
        ram_en = 1'b1;
      end
      case (state)
        S_RD: begin
          inst_valid = 1'b1;
          inst_rdata = shifted;
          inst_count = 2'd3 - off_q;
`ifdef CPU7_IMEM_UNCACHE_EN
          if (unc_q) begin
            inst_rdata   = {96'd0, shifted[31:0]};
            inst_count   = 2'd0;
            inst_uncache = 1'b1;
          end
`endif
        end
        S_EXC: begin
          inst_valid   = 1'b1;
          inst_ex      = 1'b1;
          inst_exccode = EXC_ADEF;
        end
        default: begin
          inst_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_imem_resp.sv
// tb_cpu7_ifu_imem_resp: scoreboard bench for cpu7_ifu_imem_resp.
// Three instances are used: WAIT_CYCLES=0 (dut 0), WAIT_CYCLES=3 (dut 1), and BASE_ADDR=32'hA000_0000 (dut 2).
// Expected responses are queued when a request is issued.
// A negedge monitor pops an entry and compares it whenever an instance raises inst_valid.
// When compiled with CPU7_IMEM_UNCACHE_EN, the uncached expectation for dut 2 follows that macro.

module tb_cpu7_ifu_imem_resp;

  localparam logic [127:0] L0 = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
  localparam logic [127:0] L1 = 128'h0001DDDD_0001CCCC_0001BBBB_0001AAAA;
  localparam logic [127:0] L2 = 128'h0002DDDD_0002CCCC_0002BBBB_0002AAAA;
  localparam logic [127:0] L3 = 128'h0003DDDD_0003CCCC_0003BBBB_0003AAAA;

  typedef struct {
    logic [127:0] rdata;
    logic [1:0]   count;
    logic         ex;
    logic [5:0]   exccode;
    logic         unc;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         req_s       [3];
  logic [31:0]  addr_s      [3];
  logic         cancel_s    [3];
  logic         addr_ok_s   [3];
  logic         valid_s     [3];
  logic [127:0] rdata_s     [3];
  logic [1:0]   count_s     [3];
  logic         ex_s        [3];
  logic [5:0]   exc_s       [3];
  logic         unc_s       [3];
  logic         ram_en_s    [3];
  logic [11:0]  ram_addr_s  [3];
  logic [127:0] ram_rdata_s [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  cpu7_ifu_imem_resp #(.ADDR_WIDTH(12), .BASE_ADDR(32'h1c00_0000), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .inst_req(req_s[0]), .inst_addr(addr_s[0]),
    .inst_cancel(cancel_s[0]), .inst_addr_ok(addr_ok_s[0]), .inst_valid(valid_s[0]),
    .inst_rdata(rdata_s[0]), .inst_count(count_s[0]), .inst_ex(ex_s[0]),
    .inst_exccode(exc_s[0]), .inst_uncache(unc_s[0]), .ram_en(ram_en_s[0]),
    .ram_addr(ram_addr_s[0]), .ram_rdata(ram_rdata_s[0]));

  cpu7_ifu_imem_resp #(.ADDR_WIDTH(12), .BASE_ADDR(32'h1c00_0000), .WAIT_CYCLES(3)) dut1 (
    .clock(clock), .reset(reset), .inst_req(req_s[1]), .inst_addr(addr_s[1]),
    .inst_cancel(cancel_s[1]), .inst_addr_ok(addr_ok_s[1]), .inst_valid(valid_s[1]),
    .inst_rdata(rdata_s[1]), .inst_count(count_s[1]), .inst_ex(ex_s[1]),
    .inst_exccode(exc_s[1]), .inst_uncache(unc_s[1]), .ram_en(ram_en_s[1]),
    .ram_addr(ram_addr_s[1]), .ram_rdata(ram_rdata_s[1]));

  cpu7_ifu_imem_resp #(.ADDR_WIDTH(12), .BASE_ADDR(32'hA000_0000), .WAIT_CYCLES(0)) dut2 (
    .clock(clock), .reset(reset), .inst_req(req_s[2]), .inst_addr(addr_s[2]),
    .inst_cancel(cancel_s[2]), .inst_addr_ok(addr_ok_s[2]), .inst_valid(valid_s[2]),
    .inst_rdata(rdata_s[2]), .inst_count(count_s[2]), .inst_ex(ex_s[2]),
    .inst_exccode(exc_s[2]), .inst_uncache(unc_s[2]), .ram_en(ram_en_s[2]),
    .ram_addr(ram_addr_s[2]), .ram_rdata(ram_rdata_s[2]));

  // Free-running clock with a 10-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [127:0] line_of(input logic [11:0] idx);
    logic [15:0] hi;
    hi = {4'd0, idx};
    return {hi, 16'hDDDD, hi, 16'hCCCC, hi, 16'hBBBB, hi, 16'hAAAA};
  endfunction

  // Synchronous SRAM model: data for the enabled line appears the cycle after ram_en.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (ram_en_s[i]) ram_rdata_s[i] <= line_of(ram_addr_s[i]);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [127:0] rd, input logic [1:0] cnt,
                      input logic ex, input logic unc);
    exp_t e;
    e.rdata   = rd;
    e.count   = cnt;
    e.ex      = ex;
    e.exccode = ex ? 6'h08 : 6'h00;
    e.unc     = unc;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int i);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (i)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d unexpected_valid: got valid=1, want no response", i);
    end else begin
      check($sformatf("dut%0d resp_rdata", i), rdata_s[i], e.rdata);
      check($sformatf("dut%0d resp_count", i), 128'(count_s[i]), 128'(e.count));
      check($sformatf("dut%0d resp_ex", i), 128'(ex_s[i]), 128'(e.ex));
      check($sformatf("dut%0d resp_exccode", i), 128'(exc_s[i]), 128'(e.exccode));
      check($sformatf("dut%0d resp_uncache", i), 128'(unc_s[i]), 128'(e.unc));
    end
  endtask

  // Monitor: every valid response is compared against the head of that instance's queue.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_s[i]) pop_check(i);
      end
    end
  end

  // One clock cycle on instance i: drive the inputs, check the handshake outputs at the negedge, then advance past the edge.
  task automatic applyStimulus(input int i, input logic r, input logic [31:0] a, input logic c,
                               input logic ok, input logic en, input logic [11:0] ra,
                               input logic v, input string tag);
    req_s[i]    = r;
    addr_s[i]   = a;
    cancel_s[i] = c;
    @(negedge clock);
    check({tag, " addr_ok"}, 128'(addr_ok_s[i]), 128'(ok));
    check({tag, " ram_en"}, 128'(ram_en_s[i]), 128'(en));
    check({tag, " valid"}, 128'(valid_s[i]), 128'(v));
    if (en) check({tag, " ram_addr"}, 128'(ram_addr_s[i]), 128'(ra));
    @(posedge clock);
    #1;
    req_s[i]    = 1'b0;
    cancel_s[i] = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    for (int i = 0; i < 3; i++) begin
      req_s[i]    = 1'b0;
      addr_s[i]   = 32'd0;
      cancel_s[i] = 1'b0;
    end
    reset     = 1'b1;
    req_s[0]  = 1'b1;
    addr_s[0] = 32'h1c00_0000;
    @(negedge clock);
    check("reset addr_ok", 128'(addr_ok_s[0]), 128'd0);
    check("reset valid", 128'(valid_s[0]), 128'd0);
    check("reset ram_en", 128'(ram_en_s[0]), 128'd0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    req_s[0] = 1'b0;
    @(negedge clock);
    check("post_reset rdata", rdata_s[0], 128'd0);
    check("post_reset ram_addr", 128'(ram_addr_s[0]), 128'd0);
    check("post_reset valid", 128'(valid_s[1]), 128'd0);
    @(posedge clock);
    #1;

    // Word 0 of line 0: full line, count 3.
    applyStimulus(0, 1, 32'h1c00_0000, 0, 1, 1, 12'd0, 0, "a0_req");
    push(0, L0, 2'd3, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 12'd0, 1, "a0_rsp");

    // Word 2: upper half zero-filled, count 1.
    applyStimulus(0, 1, 32'h1c00_0008, 0, 1, 1, 12'd0, 0, "a8_req");
    push(0, 128'h0000DDDD_0000CCCC, 2'd1, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 12'd0, 1, "a8_rsp");

    // Misaligned address faults, and no accept is allowed in the EXC cycle.
    applyStimulus(0, 1, 32'h1c00_0002, 0, 1, 0, 12'd0, 0, "mis_req");
    push(0, 128'd0, 2'd0, 1, 0);
    applyStimulus(0, 1, 32'h1c00_0010, 0, 0, 0, 12'd0, 1, "mis_exc");
    applyStimulus(0, 1, 32'h1c00_0010, 0, 1, 1, 12'd1, 0, "mis_retry");
    push(0, L1, 2'd3, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 12'd0, 1, "mis_retry_rsp");

    // Addresses outside the window fault.
    applyStimulus(0, 1, 32'h0000_0000, 0, 1, 0, 12'd0, 0, "low_req");
    push(0, 128'd0, 2'd0, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 12'd0, 1, "low_rsp");
    applyStimulus(0, 1, 32'hA000_0004, 0, 1, 0, 12'd0, 0, "hi_req");
    push(0, 128'd0, 2'd0, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 12'd0, 1, "hi_rsp");

    // Back-to-back requests produce one response per cycle.
    applyStimulus(0, 1, 32'h1c00_0000, 0, 1, 1, 12'd0, 0, "b2b_0");
    push(0, L0, 2'd3, 0, 0);
    applyStimulus(0, 1, 32'h1c00_0010, 0, 1, 1, 12'd1, 1, "b2b_1");
    push(0, L1, 2'd3, 0, 0);
    applyStimulus(0, 1, 32'h1c00_0020, 0, 1, 1, 12'd2, 1, "b2b_2");
    push(0, L2, 2'd3, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 12'd0, 1, "b2b_end");

    // A cancel in the RD cycle kills the response and refuses a request in the same cycle.
    applyStimulus(0, 1, 32'h1c00_0004, 0, 1, 1, 12'd0, 0, "can_req");
    applyStimulus(0, 1, 32'h1c00_0030, 1, 0, 0, 12'd0, 0, "can_rd");
    applyStimulus(0, 1, 32'h1c00_0030, 0, 1, 1, 12'd3, 0, "can_retry");
    push(0, L3, 2'd3, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 12'd0, 1, "can_rsp");

    // WAIT_CYCLES=3: accept at t, ram_en at t+3, valid at t+4.
    applyStimulus(1, 1, 32'h1c00_0010, 0, 1, 0, 12'd0, 0, "w_t0");
    applyStimulus(1, 1, 32'h1c00_0020, 0, 0, 0, 12'd0, 0, "w_t1");
    applyStimulus(1, 1, 32'h1c00_0020, 0, 0, 0, 12'd0, 0, "w_t2");
    applyStimulus(1, 1, 32'h1c00_0020, 0, 0, 1, 12'd1, 0, "w_t3");
    push(1, L1, 2'd3, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 12'd0, 1, "w_t4");

    // A cancel during WAIT drops the request; the next request is accepted the following cycle.
    applyStimulus(1, 1, 32'h1c00_0000, 0, 1, 0, 12'd0, 0, "wc_req");
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 12'd0, 0, "wc_w1");
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 12'd0, 0, "wc_cancel");
    applyStimulus(1, 1, 32'h1c00_0020, 0, 1, 0, 12'd0, 0, "wc_t0");
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 12'd0, 0, "wc_t1");
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 12'd0, 0, "wc_t2");
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 12'd2, 0, "wc_t3");
    push(1, L2, 2'd3, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 12'd0, 1, "wc_t4");

    // Faults keep their one-cycle latency even with wait states configured.
    applyStimulus(1, 1, 32'h1c00_0006, 0, 1, 0, 12'd0, 0, "wf_req");
    push(1, 128'd0, 2'd0, 1, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 12'd0, 1, "wf_rsp");

    // Window at 0xA000_0000, word 1.
    applyStimulus(2, 1, 32'hA000_0004, 0, 1, 1, 12'd0, 0, "u_req");
`ifdef CPU7_IMEM_UNCACHE_EN
    push(2, 128'h0000BBBB, 2'd0, 0, 1);
`else
    push(2, 128'h0000DDDD_0000CCCC_0000BBBB, 2'd2, 0, 0);
`endif
    applyStimulus(2, 0, 32'h0, 0, 0, 0, 12'd0, 1, "u_rsp");

    repeat (3) @(posedge clock);
    #1;
    check("q0 drained", 128'(q0.size()), 128'd0);
    check("q1 drained", 128'(q1.size()), 128'd0);
    check("q2 drained", 128'(q2.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
